// File: rtl/modport_subordinate.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | modport_subordinate                                                       |
// | AXI4-lite subordinate fronting a word-addressed register bank.            |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module modport_subordinate #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [2:0]            bresp
);

  localparam int c_BYTES = DATA_WIDTH / 8;
  localparam int c_OFFS  = $clog2(c_BYTES);
  localparam int c_IDXW  = $clog2(NUM_REGS);
  localparam int c_SPANW = c_OFFS + c_IDXW;

  localparam logic [2:0] c_RESP_OKAY   = 3'b000;
  localparam logic [2:0] c_RESP_SLVERR = 3'b010;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rstate_t;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  // Read path
  rstate_t               r_rstate;
  rstate_t               w_rstate_nx;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_ar_hit;
  logic [c_IDXW-1:0]     w_ar_idx;

  // BASE_ADDR is aligned to the bank span, so the upper bits alone decide a hit
  // and the index is just the bits between the byte offset and the span.
  assign w_ar_hit = (araddr[ADDR_WIDTH-1:c_SPANW] == BASE_ADDR[ADDR_WIDTH-1:c_SPANW]);
  assign w_ar_idx = araddr[c_SPANW-1:c_OFFS];
  assign w_ar_hs  = arvalid & r_arready;
  assign w_r_hs   = r_rvalid & rready;

  always_comb begin
    w_rstate_nx = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nx = R_RESP;
      R_RESP:  if (w_r_hs)  w_rstate_nx = R_IDLE;
      default: w_rstate_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rstate  <= w_rstate_nx;
      r_arready <= (w_rstate_nx == R_IDLE);
      r_rvalid  <= (w_rstate_nx == R_RESP);
      if (w_ar_hs) r_rdata <= w_ar_hit ? r_regs[w_ar_idx] : '0;
    end
  end

  // Write path
  logic                  r_aw_held;
  logic                  r_w_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [2:0]            r_bresp;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic                  w_wr_hit;
  logic [c_IDXW-1:0]     w_wr_idx;
  logic                  w_aw_held_nx;
  logic                  w_w_held_nx;
  logic                  w_bvalid_nx;

  assign w_aw_hs   = awvalid & r_awready;
  assign w_w_hs    = wvalid & r_wready;
  assign w_b_hs    = r_bvalid & bready;
  // A channel arriving this cycle pairs directly with one already held.
  assign w_commit  = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
  assign w_wr_addr = r_aw_held ? r_awaddr : awaddr;
  assign w_wr_data = r_w_held ? r_wdata : wdata;
  assign w_wr_hit  = (w_wr_addr[ADDR_WIDTH-1:c_SPANW] == BASE_ADDR[ADDR_WIDTH-1:c_SPANW]);
  assign w_wr_idx  = w_wr_addr[c_SPANW-1:c_OFFS];

  always_comb begin
    w_aw_held_nx = r_aw_held;
    w_w_held_nx  = r_w_held;
    w_bvalid_nx  = r_bvalid;
    if (w_aw_hs) w_aw_held_nx = 1'b1;
    if (w_w_hs)  w_w_held_nx  = 1'b1;
    if (w_commit) begin
      w_aw_held_nx = 1'b0;
      w_w_held_nx  = 1'b0;
      w_bvalid_nx  = 1'b1;
    end
    if (w_b_hs) w_bvalid_nx = 1'b0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= c_RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_aw_held <= w_aw_held_nx;
      r_w_held  <= w_w_held_nx;
      r_bvalid  <= w_bvalid_nx;
      r_awready <= ~w_bvalid_nx & ~w_aw_held_nx;
      r_wready  <= ~w_bvalid_nx & ~w_w_held_nx;
      if (w_aw_hs) r_awaddr <= awaddr;
      if (w_w_hs)  r_wdata  <= wdata;
      if (w_commit) begin
        r_bresp <= w_wr_hit ? c_RESP_OKAY : c_RESP_SLVERR;
        if (w_wr_hit) r_regs[w_wr_idx] <= w_wr_data;
      end
    end
  end

  logic w_unused;
  assign w_unused = ^{araddr[c_OFFS-1:0], w_wr_addr[c_OFFS-1:0]};

  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;

endmodule
`default_nettype wire

// File: tb/tb_modport_subordinate.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_modport_subordinate                                                    |
// | Self-checking bench: vector table, directed corners, random vs model.     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_modport_subordinate;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          NREGS = 16;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int          WBYTES = DW / 8;
  localparam int          SPAN  = NREGS * WBYTES;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] araddr;
  logic [DW-1:0] rdata;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [AW-1:0] awaddr;
  logic [DW-1:0] wdata;
  logic [2:0]    bresp;

  always #5 clk = ~clk;

  modport_subordinate #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NREGS), .BASE_ADDR(BASE)
  ) dut (
    .aclk(clk), .aresetn(aresetn),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model [NREGS];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (64'(a) - 64'(BASE)) < 64'(SPAN);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((64'(a) - 64'(BASE)) / 64'(WBYTES));
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    return in_range(a) ? model[idx_of(a)] : 32'h0;
  endfunction

  function automatic logic [2:0] exp_resp(input logic [31:0] a);
    return in_range(a) ? 3'b000 : 3'b010;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    if (in_range(a)) model[idx_of(a)] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
  endtask

  // lat = number of cycles between the last handshake and the response (0 expected).
  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input int aw_dly, input int w_dly, input int b_dly,
                          output logic [2:0] resp, output int lat);
    bit aw_done, w_done, ha, hw;
    int t;
    @(negedge clk);
    awaddr = a; wdata = d; bready = 1'b0;
    aw_done = 0; w_done = 0; t = 0;
    while (!(aw_done && w_done) && t < 40) begin
      awvalid = !aw_done && (t >= aw_dly);
      wvalid  = !w_done && (t >= w_dly);
      ha = awvalid && awready;
      hw = wvalid && wready;
      @(negedge clk);
      t++;
      if (ha) aw_done = 1;
      if (hw) w_done = 1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    lat = (aw_done && w_done) ? 0 : 99;
    while (!bvalid && lat < 20) begin @(negedge clk); lat++; end
    resp = bresp;
    repeat (b_dly) @(negedge clk);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int r_dly,
                         output logic [31:0] d, output int lat);
    int t;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b0; t = 0;
    while (!arready && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    arvalid = 1'b0;
    lat = (t < 20) ? 0 : 99;
    while (!rvalid && lat < 20) begin @(negedge clk); lat++; end
    d = rdata;
    repeat (r_dly) @(negedge clk);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;   // rdata for reads, bresp for writes
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [12];
    logic [31:0] d;
    logic [2:0]  resp;
    int          lat;
    bit          wr;
    logic [31:0] a;

    vecs[0]  = '{0, 32'h0000_0014, 32'h0,          32'h0};
    vecs[1]  = '{1, 32'h0000_0008, 32'hCAFE_F00D, 32'h0};
    vecs[2]  = '{0, 32'h0000_0008, 32'h0,          32'hCAFE_F00D};
    vecs[3]  = '{1, 32'h0000_0040, 32'hFFFF_FFFF, 32'h2};
    vecs[4]  = '{0, 32'h0000_0040, 32'h0,          32'h0};
    vecs[5]  = '{0, 32'h0000_0000, 32'h0,          32'h0};
    vecs[6]  = '{1, 32'h0000_003C, 32'hA5A5_5A5A, 32'h0};
    vecs[7]  = '{0, 32'h0000_003F, 32'h0,          32'hA5A5_5A5A};
    vecs[8]  = '{1, 32'hFFFF_FFFC, 32'h1111_1111, 32'h2};
    vecs[9]  = '{0, 32'h0000_003C, 32'h0,          32'hA5A5_5A5A};
    vecs[10] = '{1, 32'h0000_0001, 32'h0000_0001, 32'h0};
    vecs[11] = '{0, 32'h0000_0000, 32'h0,          32'h0000_0001};

    aresetn = 1'b0;
    arvalid = 0; araddr = '0; rready = 0;
    awvalid = 0; awaddr = '0; wvalid = 0; wdata = '0; bready = 0;
    model_clear();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_readies", 64'({arready, awready, wready}), 64'(3'b000));
    chk("rst_valids",  64'({rvalid, bvalid}), 64'(2'b00));
    chk("rst_rdata",   64'(rdata), 64'h0);
    chk("rst_bresp",   64'(bresp), 64'h0);
    aresetn = 1'b1;
    @(negedge clk);
    chk("post_rst_readies", 64'({arready, awready, wready}), 64'(3'b111));
    chk("post_rst_valids",  64'({rvalid, bvalid}), 64'(2'b00));

    // Vector table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, 0, 0, 0, resp, lat);
        model_write(vecs[i].addr, vecs[i].data);
        chk($sformatf("vec%0d_bresp", i), 64'(resp), 64'(vecs[i].exp));
        chk($sformatf("vec%0d_wlat", i), 64'(lat), 64'd0);
      end else begin
        do_read(vecs[i].addr, 0, d, lat);
        chk($sformatf("vec%0d_rdata", i), 64'(d), 64'(vecs[i].exp));
        chk($sformatf("vec%0d_rlat", i), 64'(lat), 64'd0);
      end
    end

    // Every register still matches the model (no stray out-of-range writes)
    for (int i = 0; i < NREGS; i++) begin
      do_read(BASE + 32'(i * WBYTES), 0, d, lat);
      chk($sformatf("sweep%0d", i), 64'(d), 64'(model[i]));
    end

    // W three cycles ahead of AW
    @(negedge clk);
    wdata = 32'h1234_5678; wvalid = 1'b1; bready = 1'b0;
    chk("wfirst_pre_wready", 64'(wready), 64'd1);
    @(negedge clk);
    wvalid = 1'b0;
    chk("wfirst_wready_drop", 64'({wready, awready, bvalid}), 64'(3'b010));
    repeat (2) @(negedge clk);
    chk("wfirst_no_bvalid", 64'({wready, bvalid}), 64'(2'b00));
    awaddr = 32'h4; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    model_write(32'h4, 32'h1234_5678);
    chk("wfirst_bvalid", 64'({bvalid, bresp}), 64'({1'b1, 3'b000}));
    chk("wfirst_closed", 64'({awready, wready}), 64'(2'b00));
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("wfirst_reopen", 64'({bvalid, arready, awready, wready}), 64'(4'b0111));
    do_read(32'h4, 0, d, lat);
    chk("wfirst_read4", 64'(d), 64'(exp_read(32'h4)));
    do_read(32'h6, 0, d, lat);
    chk("wfirst_read6", 64'(d), 64'(32'h1234_5678));

    // Backpressure on both response channels
    @(negedge clk);
    araddr = 32'h8; arvalid = 1'b1;
    awaddr = 32'h10; wdata = 32'h5555_AAAA; awvalid = 1'b1; wvalid = 1'b1;
    rready = 1'b0; bready = 1'b0;
    chk("bp_pre_readies", 64'({arready, awready, wready}), 64'(3'b111));
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    model_write(32'h10, 32'h5555_AAAA);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valids%0d", k), 64'({rvalid, bvalid}), 64'(2'b11));
      chk($sformatf("bp_rdata%0d", k), 64'(rdata), 64'(32'hCAFE_F00D));
      chk($sformatf("bp_bresp%0d", k), 64'(bresp), 64'h0);
      chk($sformatf("bp_readies%0d", k), 64'({arready, awready, wready}), 64'(3'b000));
      @(negedge clk);
    end
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    chk("bp_release", 64'({rvalid, bvalid, arready, awready, wready}), 64'(5'b00111));

    // Same-edge read and write of one register returns the old value
    do_write(32'hC, 32'h1, 0, 0, 0, resp, lat);
    model_write(32'hC, 32'h1);
    @(negedge clk);
    araddr = 32'hC; arvalid = 1'b1;
    awaddr = 32'hC; wdata = 32'h2; awvalid = 1'b1; wvalid = 1'b1;
    chk("sim_pre_readies", 64'({arready, awready, wready}), 64'(3'b111));
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("sim_old_value", 64'(rdata), 64'(32'h1));
    chk("sim_valids", 64'({rvalid, bvalid}), 64'(2'b11));
    model_write(32'hC, 32'h2);
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    do_read(32'hC, 0, d, lat);
    chk("sim_new_value", 64'(d), 64'(32'h2));

    // Asynchronous reset mid-read, with write data held
    @(negedge clk);
    araddr = 32'h8; arvalid = 1'b1; wdata = 32'hDEAD_BEEF; wvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; wvalid = 1'b0;
    chk("mid_rvalid", 64'({rvalid, wready}), 64'(2'b10));
    #2;
    aresetn = 1'b0;
    #1;
    chk("mid_rst_immediate", 64'({rvalid, arready, wready, awready}), 64'(4'b0000));
    chk("mid_rst_rdata", 64'(rdata), 64'h0);
    model_clear();
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    chk("mid_rst_release", 64'({arready, awready, wready, rvalid}), 64'(4'b1110));
    awaddr = 32'h10; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("mid_rst_wbuf_cleared", 64'(bvalid), 64'd0);
    wdata = 32'h77; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("mid_rst_commit", 64'(bvalid), 64'd1);
    model_write(32'h10, 32'h77);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    do_read(32'h8, 0, d, lat);
    chk("mid_rst_regs_cleared", 64'(d), 64'(exp_read(32'h8)));
    do_read(32'h10, 0, d, lat);
    chk("mid_rst_new_write", 64'(d), 64'(exp_read(32'h10)));

    // Randomized traffic against the reference model
    for (int n = 0; n < 150; n++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = $urandom();
      else a = BASE + 32'($urandom_range(0, SPAN - 1));
      if (wr) begin
        d = $urandom();
        do_write(a, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), resp, lat);
        chk($sformatf("rnd%0d_bresp@%h", n, a), 64'(resp), 64'(exp_resp(a)));
        chk($sformatf("rnd%0d_wlat", n), 64'(lat), 64'd0);
        model_write(a, d);
      end else begin
        do_read(a, int'($urandom_range(0, 3)), d, lat);
        chk($sformatf("rnd%0d_rdata@%h", n, a), 64'(d), 64'(exp_read(a)));
        chk($sformatf("rnd%0d_rlat", n), 64'(lat), 64'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
